// File: rtl/fetch_queue_d_if.sv
// Fetch/decode handshake bundle for fetch_queue_d.
// master: fetch and decode side (drives fetch data and stall).
// slave:  the queue (drives ready, head data and occupancy).
interface fetch_queue_d_if #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned DEPTH      = 4
);
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    // Fetch side.
    logic                  ValidF;
    logic                  ReadyF;
    logic [DATA_WIDTH-1:0] RD;
    logic [DATA_WIDTH-1:0] PCF;
    logic [DATA_WIDTH-1:0] PCPlus4F;

    // Decode side.
    logic                  StallD;
    logic                  ValidD;
    logic [DATA_WIDTH-1:0] InstrD;
    logic [DATA_WIDTH-1:0] PCD;
    logic [DATA_WIDTH-1:0] PCPlus4D;
    logic [CNT_W-1:0]      CountD;

    modport master (
        output ValidF, RD, PCF, PCPlus4F, StallD,
        input  ReadyF, InstrD, PCD, PCPlus4D, ValidD, CountD
    );

    modport slave (
        input  ValidF, RD, PCF, PCPlus4F, StallD,
        output ReadyF, InstrD, PCD, PCPlus4D, ValidD, CountD
    );
endinterface

// File: rtl/fetch_queue_d.sv
// Fetch-to-decode stage buffer: DEPTH-entry FIFO of {instr, pc, pc+4}.
// Head is shown combinationally from storage, so an entry pushed into an
// empty queue is visible right after its write edge. Outputs read as zero
// when empty so decode sees a bubble.
module fetch_queue_d #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned DEPTH      = 4
) (
    input logic             CLK,
    input logic             RST,
    input logic             CLR,
    fetch_queue_d_if.slave  bus
);
    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    logic [DATA_WIDTH-1:0] instr_mem [DEPTH];
    logic [DATA_WIDTH-1:0] pc_mem    [DEPTH];
    logic [DATA_WIDTH-1:0] pc4_mem   [DEPTH];

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;

    logic ready, valid, push, pop;

    // Handshake status from registered occupancy only (no StallD -> ReadyF path).
    always_comb begin
        ready = (count_q != CNT_W'(DEPTH));
        valid = (count_q != '0);
        push  = bus.ValidF && ready;
        pop   = valid && !bus.StallD;
    end

    // Next-state for pointers and count; flush overrides push and pop.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (CLR) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) begin
                wr_ptr_d = wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            if (push && !pop) begin
                count_d = count_q + CNT_W'(1);
            end else if (pop && !push) begin
                count_d = count_q - CNT_W'(1);
            end
        end
    end

    // Pointer and occupancy registers with asynchronous reset.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Entry storage; contents are don't-care after reset or flush.
    always_ff @(posedge CLK) begin
        if (push && !CLR) begin
            instr_mem[wr_ptr_q] <= bus.RD;
            pc_mem[wr_ptr_q]    <= bus.PCF;
            pc4_mem[wr_ptr_q]   <= bus.PCPlus4F;
        end
    end

    // Decode-side outputs, zeroed when empty.
    always_comb begin
        bus.ReadyF   = ready;
        bus.ValidD   = valid;
        bus.CountD   = count_q;
        bus.InstrD   = '0;
        bus.PCD      = '0;
        bus.PCPlus4D = '0;
        if (valid) begin
            bus.InstrD   = instr_mem[rd_ptr_q];
            bus.PCD      = pc_mem[rd_ptr_q];
            bus.PCPlus4D = pc4_mem[rd_ptr_q];
        end
    end
endmodule

// File: tb/tb_fetch_queue_d.sv
// Bench for fetch_queue_d: directed scenarios plus random traffic,
// checked against a queue-based reference model.
module tb_fetch_queue_d;
    localparam int unsigned DW    = 32;
    localparam int unsigned DEPTH = 4;

    typedef struct {
        logic [DW-1:0] instr;
        logic [DW-1:0] pc;
        logic [DW-1:0] pc4;
    } entry_t;

    logic CLK = 1'b0;
    logic RST;
    logic CLR;

    fetch_queue_d_if #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) bus ();

    fetch_queue_d #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
        .CLK (CLK),
        .RST (RST),
        .CLR (CLR),
        .bus (bus)
    );

    always #5 CLK = ~CLK;

    entry_t model[$];
    int     n_checks = 0;
    int     n_errors = 0;

    task automatic check_eq(input string tag, input logic [DW-1:0] got,
                            input logic [DW-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
        end
    endtask

    // Compare every DUT output with what the model says it should be now.
    task automatic check_model(input string tag);
        entry_t h;
        logic   v;
        v = (model.size() != 0);
        h = '{instr: '0, pc: '0, pc4: '0};
        if (v) h = model[0];
        check_eq({tag, ".ValidD"},   DW'(bus.ValidD), DW'(v));
        check_eq({tag, ".ReadyF"},   DW'(bus.ReadyF), DW'(model.size() != DEPTH));
        check_eq({tag, ".CountD"},   DW'(bus.CountD), DW'(model.size()));
        check_eq({tag, ".InstrD"},   bus.InstrD, h.instr);
        check_eq({tag, ".PCD"},      bus.PCD, h.pc);
        check_eq({tag, ".PCPlus4D"}, bus.PCPlus4D, h.pc4);
    endtask

    task automatic drive(input logic v, input logic [DW-1:0] instr, input logic [DW-1:0] pc);
        bus.ValidF   = v;
        bus.RD       = instr;
        bus.PCF      = pc;
        bus.PCPlus4F = pc + 32'd4;
    endtask

    // One clock: check mid-cycle, advance model at the edge, return #1 after it.
    task automatic step(input string tag);
        bit     push, pop, clr;
        entry_t e;
        @(negedge CLK);
        check_model(tag);
        push = bus.ValidF && (model.size() != DEPTH);
        pop  = (model.size() != 0) && !bus.StallD;
        clr  = CLR;
        e    = '{instr: bus.RD, pc: bus.PCF, pc4: bus.PCPlus4F};
        @(posedge CLK);
        if (clr) begin
            model.delete();
        end else begin
            if (pop) void'(model.pop_front());
            if (push) model.push_back(e);
        end
        #1;
    endtask

    task automatic drain();
        drive(1'b0, '0, '0);
        bus.StallD = 1'b0;
        for (int i = 0; i < 2 * DEPTH && model.size() != 0; i++) step("drain");
        check_eq("drain.empty", DW'(bus.ValidD), 32'd0);
    endtask

    initial begin
        int pushed;
        logic [DW-1:0] pc;
        RST = 1'b1;
        CLR = 1'b0;
        bus.StallD = 1'b0;
        drive(1'b0, '0, '0);
        #1;
        check_model("reset");
        @(posedge CLK);
        @(posedge CLK);
        #1 RST = 1'b0;

        // Reset mid-stream: three entries queued, then asynchronous reset.
        bus.StallD = 1'b1;
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, $urandom, 32'h40 + 32'(i) * 4);
            step("rst_fill");
        end
        check_eq("rst_fill.count", DW'(bus.CountD), 32'd3);
        drive(1'b0, '0, '0);
        @(negedge CLK);
        RST = 1'b1;
        #1;
        model.delete();
        check_eq("async_rst.ValidD", DW'(bus.ValidD), 32'd0);
        check_eq("async_rst.InstrD", bus.InstrD, 32'd0);
        check_eq("async_rst.PCD", bus.PCD, 32'd0);
        check_eq("async_rst.CountD", DW'(bus.CountD), 32'd0);
        check_eq("async_rst.ReadyF", DW'(bus.ReadyF), 32'd1);
        @(posedge CLK);
        #1 RST = 1'b0;
        drive(1'b1, 32'h0050_0093, 32'h100);
        step("post_rst_push");
        check_eq("post_rst.InstrD", bus.InstrD, 32'h0050_0093);
        check_eq("post_rst.PCD", bus.PCD, 32'h100);
        check_eq("post_rst.PCPlus4D", bus.PCPlus4D, 32'h104);
        drain();

        // Streaming with no stall: each entry visible one cycle after push.
        bus.StallD = 1'b0;
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, $urandom, 32'(i) * 4);
            step("stream");
            check_eq("stream.PCD", bus.PCD, 32'(i) * 4);
            check_eq("stream.CountD", DW'(bus.CountD), 32'd1);
        end
        drain();

        // Fill to full, hold a fifth entry, then stream 3*DEPTH entries through.
        bus.StallD = 1'b1;
        pushed = 0;
        pc = 32'h400;
        for (int i = 0; i < DEPTH; i++) begin
            drive(1'b1, $urandom, pc);
            step("fill");
            pc += 4;
            pushed++;
        end
        check_eq("full.ReadyF", DW'(bus.ReadyF), 32'd0);
        check_eq("full.CountD", DW'(bus.CountD), 32'(DEPTH));
        drive(1'b1, $urandom, pc);
        step("held");
        step("held");
        check_eq("held.CountD", DW'(bus.CountD), 32'(DEPTH));
        bus.StallD = 1'b0;
        for (int cyc = 0; cyc < 100 && pushed < 3 * DEPTH; cyc++) begin
            bit acc;
            acc = (model.size() != DEPTH);
            step("wrap");
            check_eq("wrap.count_band", DW'(bus.CountD >= 3'(DEPTH - 1)), 32'd1);
            if (acc) begin
                pushed++;
                pc += 4;
                drive(1'b1, $urandom, pc);
            end
        end
        check_eq("wrap.pushed", 32'(pushed), 32'(3 * DEPTH));
        drain();

        // Flush with a concurrent push.
        bus.StallD = 1'b1;
        for (int i = 0; i < 2; i++) begin
            drive(1'b1, $urandom, 32'h180 + 32'(i) * 4);
            step("pre_flush");
        end
        CLR = 1'b1;
        drive(1'b1, 32'hdead_beef, 32'h200);
        step("flush");
        CLR = 1'b0;
        check_eq("flush.ValidD", DW'(bus.ValidD), 32'd0);
        check_eq("flush.InstrD", bus.InstrD, 32'd0);
        check_eq("flush.PCD", bus.PCD, 32'd0);
        check_eq("flush.PCPlus4D", bus.PCPlus4D, 32'd0);
        check_eq("flush.CountD", DW'(bus.CountD), 32'd0);
        check_eq("flush.ReadyF", DW'(bus.ReadyF), 32'd1);
        drive(1'b1, 32'h1234_5678, 32'h300);
        step("post_flush");
        check_eq("post_flush.PCD", bus.PCD, 32'h300);
        check_eq("post_flush.ValidD", DW'(bus.ValidD), 32'd1);
        drain();

        // Stall while empty, then one entry held until stall drops.
        bus.StallD = 1'b1;
        drive(1'b0, '0, '0);
        step("empty_stall");
        check_eq("empty_stall.ValidD", DW'(bus.ValidD), 32'd0);
        drive(1'b1, 32'h0000_0013, 32'h500);
        step("stall_push");
        check_eq("stall_push.ValidD", DW'(bus.ValidD), 32'd1);
        drive(1'b0, '0, '0);
        step("stall_hold");
        step("stall_hold");
        check_eq("stall_hold.PCD", bus.PCD, 32'h500);
        bus.StallD = 1'b0;
        step("stall_release");
        check_eq("stall_release.ValidD", DW'(bus.ValidD), 32'd0);

        // Random traffic; fetch holds an unaccepted entry like real fetch.
        pc = 32'h1000;
        drive(1'b0, '0, pc);
        for (int cyc = 0; cyc < 400; cyc++) begin
            bit acc;
            acc = bus.ValidF && (model.size() != DEPTH) && !CLR;
            if (acc || !bus.ValidF || CLR) begin
                pc += 4;
                drive($urandom_range(0, 9) < 7, $urandom, pc);
            end
            bus.StallD = $urandom_range(0, 9) < 4;
            CLR = $urandom_range(0, 39) == 0;
            step("rand");
        end
        CLR = 1'b0;
        drain();

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end
endmodule

// File: doc/fetch_queue_d.md
# fetch_queue_d

Parametrised fetch-to-decode stage buffer replacing the single-entry F/D pipeline register. It holds up to `DEPTH` fetched instructions with their PC and PC+4, so fetch keeps running while decode is stalled. Valid/ready handshakes on both sides, a synchronous flush for branch mispredicts, and zeroed outputs when empty, so decode sees a bubble exactly as after a flush. It sits between the instruction memory read port and the decode stage.

## Interface
- `DATA_WIDTH`, 32, width of instruction, PC and PC+4 fields
- `DEPTH`, 4, number of queue entries; power of two, >= 2
- `CLK` in 1: rising-edge clock
- `RST` in 1: asynchronous, active-high reset
- `CLR` in 1: synchronous flush, active-high
- `ValidF` in 1: fetch presents a valid entry this cycle
- `RD` in DATA_WIDTH: fetched instruction
- `PCF` in DATA_WIDTH: PC of fetched instruction
- `PCPlus4F` in DATA_WIDTH: PC+4 of fetched instruction
- `ReadyF` out 1: queue can accept an entry (not full)
- `StallD` in 1: decode cannot consume the head entry this cycle
- `InstrD` out DATA_WIDTH: head instruction, 0 when empty
- `PCD` out DATA_WIDTH: head PC, 0 when empty
- `PCPlus4D` out DATA_WIDTH: head PC+4, 0 when empty
- `ValidD` out 1: head entry valid (queue non-empty)
- `CountD` out $clog2(DEPTH+1): number of occupied entries

## Operation
- Storage: `DEPTH` entries of {instr, pc, pcplus4}. Write pointer, read pointer ($clog2(DEPTH) bits, wrap modulo DEPTH), occupancy counter.
- Push = `ValidF && ReadyF`. Writes {RD, PCF, PCPlus4F} at write pointer. Write pointer increments.
- Pop = `ValidD && !StallD`. Read pointer increments.
- `ReadyF` = (count != DEPTH). Derived from registered state only; no combinational path from `StallD`.
- `ValidD` = (count != 0).
- D outputs = entry at read pointer when `ValidD`, else all zero.
- Count update on simultaneous push and pop: unchanged. Push only: +1. Pop only: −1.
- Push while full cannot occur, because `ReadyF` is low. `ValidF` while full is ignored, and fetch must hold its entry.
- Pop while empty cannot occur, because `ValidD` is low. `StallD` is a don't-care when empty.
- Full with pop: the entry is removed; `ReadyF` rises the next cycle, not the same cycle.
- `CLR`:
  - On the next edge: count, read pointer and write pointer go to 0, and storage contents are don't-care.
  - Overrides push and pop in the same cycle. An entry presented with `CLR` high is discarded.
- `RST` (asynchronous, any time, including mid-stream): count and pointers go to 0 immediately and outputs go to reset values. Storage is not required to be cleared.

## Timing
- Reset values:
  - `ValidD`=0, `InstrD`=0, `PCD`=0, `PCPlus4D`=0
  - `CountD`=0, `ReadyF`=1
- Latency: an entry pushed at edge k appears on D outputs (if the queue was empty) immediately after edge k. This is the same one-cycle latency as a plain pipeline register.
- Throughput: one push and one pop per cycle sustained; no bubbles when `StallD` is low.
- After `CLR` at edge k: `ValidD`=0 and outputs are 0 from edge k. `ReadyF`=1 from edge k. A push is accepted on edge k+1.
- Ordering: strict FIFO, including across pointer wrap-around.
- All state changes on the rising edge of `CLK`, except the asynchronous assertion of `RST`.

## Test plan
- **Reset mid-stream:** fill 3 entries, assert `RST` between edges.
  - Required: outputs go to 0 and `ReadyF`=1 without waiting for an edge.
  - After release, a push of RD=0x00500093, PCF=0x100 appears next cycle with PCPlus4D=0x104.
- **Streaming, no stall:** push 8 entries back-to-back with PCF=0x0,0x4,…,0x1C and `StallD`=0.
  - Required: each entry appears on `PCD` one cycle after its push.
  - `CountD` stays at 1; no bubbles.
- **Fill and wrap:** hold `StallD`=1, push with DEPTH=4.
  - Required: `ReadyF` falls after the 4th push; `CountD`=4. A 5th entry held on `ValidF` is not accepted.
  - Release `StallD`: entries drain in order. The held entry is accepted the cycle after `ReadyF` rises.
  - Continue for 3 × DEPTH entries so the pointers wrap, with order preserved.
- **Simultaneous push and pop at full:** hold `StallD`=0 and `ValidF`=1 while full.
  - Required: the count stays at DEPTH−1..DEPTH as `ReadyF` toggles.
  - No entry is lost or duplicated (check PCs against a scoreboard).
- **Flush with concurrent push:** 2 entries queued; `CLR`=1 with `ValidF`=1, PCF=0x200.
  - Required: the next cycle `ValidD`=0, `InstrD`=`PCD`=`PCPlus4D`=0, `CountD`=0, and PCF=0x200 is discarded.
  - A following push of PCF=0x300 appears next cycle.
- **Stall when empty:** `StallD`=1 with an empty queue, then push one entry.
  - Required: `ValidD` rises one cycle after the push.
  - The entry is held while `StallD`=1 and removed on the first cycle with `StallD`=0.
